iic_seq_ctrl: RTL and testbench
===============================

IIC_SEQ_CTRL -- requirements
Module: iic_seq_ctrl

Interface
- REQ-001 Parameter ADDR_W, default 8, width of the EEPROM word address.
- REQ-002 Parameter DATA_W, default 8, width of the data byte.
- REQ-003 Parameter NUM_BYTES, default 16, range 1..2^ADDR_W, the number of consecutive locations per test.
- REQ-004 Parameter START_ADDR, default 0, the first location of the test.
- REQ-005 Parameter BASE_DATA, default 8'hA5, the pattern seed: expected data at index i = BASE_DATA + i, mod 2^DATA_W.
- REQ-006 Parameter WR_GAP_CYC, default 250000 (5 ms at 50 MHz), the idle cycles required after each write completes.
- REQ-007 Parameter TIMEOUT_CYC, default 1000000, the maximum number of cycles a request may wait for done_sig.
- REQ-008 Parameter ERR_W, default 8, width of the error counter.
- REQ-009 clk_50M  in  1  the single clock; all logic SHALL run on its rising edge.
- REQ-010 rst_n  in  1  asynchronous, active-low reset.
- REQ-011 start  in  1  level-sampled test request.
- REQ-012 mode  in  2  test mode: 00 = write then verify; 01 = write only; 10 = verify only; 11 = treated as 00.
- REQ-013 wr_sig  out  1  write request to the IIC core.
- REQ-014 rd_sig  out  1  read request to the IIC core.
- REQ-015 addr_sig  out  ADDR_W  word address of the current transaction.
- REQ-016 wr_data  out  DATA_W  data byte for the current write.
- REQ-017 done_sig  in  1  one-cycle completion pulse from the IIC core.
- REQ-018 rd_data  in  DATA_W  read byte, valid in the cycle done_sig=1 during a read.
- REQ-019 busy  out  1  high from the cycle start is accepted until FIN is left.
- REQ-020 test_done  out  1  one-cycle pulse at the end of a test.
- REQ-021 pass  out  1  test result, held until the next accepted start.
- REQ-022 err_cnt  out  ERR_W  count of read-back mismatches, saturating.
- REQ-023 timeout_err  out  1  set when a request times out; held until the next accepted start.

Function
- REQ-024 The FSM SHALL have the states IDLE, WR_REQ, WR_GAP, RD_REQ, RD_CMP and FIN, with a 0-based index idx.
- REQ-025 IDLE, start=1: clear err_cnt, pass, timeout_err and idx; assert busy; go to WR_REQ (modes 00, 01, 11) or RD_REQ (mode 10); mode is latched at this edge.
- REQ-026 start while busy=1 SHALL be ignored; a new test requires busy=0 and start=1.
- REQ-027 WR_REQ: wr_sig=1, addr_sig = START_ADDR+idx mod 2^ADDR_W, wr_data = BASE_DATA+idx; outputs held stable until done_sig.
- REQ-028 WR_REQ with done_sig=1 sampled: wr_sig=0 from the next cycle; load the gap counter; go to WR_GAP.
- REQ-029 WR_GAP: rd_sig=wr_sig=0 for exactly WR_GAP_CYC cycles.
- REQ-030 Leaving WR_GAP: if idx<NUM_BYTES-1, increment idx and go to WR_REQ.
- REQ-031 Leaving WR_GAP: if idx=NUM_BYTES-1, clear idx and go to RD_REQ (latched mode 00/11) or FIN (latched mode 01).
- REQ-032 RD_REQ: rd_sig=1, addr_sig = START_ADDR+idx; on done_sig=1, capture rd_data into a register, drop rd_sig next cycle, go to RD_CMP.
- REQ-033 RD_CMP (1 cycle): if captured data != BASE_DATA+idx, increment err_cnt, saturating at 2^ERR_W-1.
- REQ-034 RD_CMP then: if idx<NUM_BYTES-1, increment idx and go to RD_REQ; else go to FIN.
- REQ-035 FIN (1 cycle): test_done=1; pass = (err_cnt==0 && timeout_err==0); busy deasserts on the next cycle and the FSM returns to IDLE.
- REQ-036 wr_sig and rd_sig SHALL never both be 1; at least one cycle with both 0 SHALL separate consecutive requests.
- REQ-037 A timeout counter SHALL run while in WR_REQ or RD_REQ and clear on each new request.
- REQ-038 If the timeout counter reaches TIMEOUT_CYC without done_sig: drop the request next cycle, set timeout_err=1, go to FIN with pass=0.
- REQ-039 done_sig received in IDLE, WR_GAP, RD_CMP or FIN SHALL be ignored.
- REQ-040 When done_sig and a timeout occur in the same cycle, done_sig SHALL win.
- REQ-041 Address wrap: START_ADDR+idx SHALL wrap modulo 2^ADDR_W without error.

Reset
- REQ-042 rst_n=0 SHALL, asynchronously: set state=IDLE, idx=0, all counters to 0, and wr_sig, rd_sig, addr_sig, wr_data, busy, test_done, pass, err_cnt and timeout_err to 0.
- REQ-043 Reset asserted mid-transaction SHALL drop wr_sig/rd_sig immediately; no test_done pulse SHALL be produced.
- REQ-044 After release of rst_n the block SHALL wait for a new start.

Verification
- REQ-045 Mode 00, NUM_BYTES=4, START_ADDR=0, WR_GAP_CYC=3, core model echoing stored data -> 4 writes of A5,A6,A7,A8 to addresses 0..3, then 4 reads; test_done pulse, pass=1, err_cnt=0.
- REQ-046 Same as REQ-045 but the model corrupts the read of address 2 -> err_cnt=1, pass=0.
- REQ-047 Mode 01 -> no rd_sig ever asserted; test_done one cycle after the last gap ends; pass=1.
- REQ-048 START_ADDR=8'hFE, NUM_BYTES=4 -> addresses FE, FF, 00, 01 in order.
- REQ-049 Model never answers, TIMEOUT_CYC=10 -> wr_sig drops after 10 cycles, timeout_err=1, pass=0, one test_done pulse.
- REQ-050 rst_n pulsed low during RD_REQ -> rd_sig=0 in the same cycle, all outputs 0, no test_done; start afterwards runs a full test normally.

Source files
------------

// File: rtl/iic_seq_ctrl.sv
// iic_seq_ctrl: EEPROM write / read-back test sequencer that drives a simple
// request/done IIC core. Writes an incrementing pattern, waits out the EEPROM
// write cycle after each byte, then reads every location back and counts
// mismatches. A per-request timeout aborts the test if the core never answers.
module iic_seq_ctrl #(
  parameter int                ADDR_W      = 8,
  parameter int                DATA_W      = 8,
  parameter int                NUM_BYTES   = 16,
  parameter logic [ADDR_W-1:0] START_ADDR  = '0,
  parameter logic [DATA_W-1:0] BASE_DATA   = 8'hA5,
  parameter int                WR_GAP_CYC  = 250000,
  parameter int                TIMEOUT_CYC = 1000000,
  parameter int                ERR_W       = 8
) (
  input  logic              clk_50M,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        mode,
  output logic              wr_sig,
  output logic              rd_sig,
  output logic [ADDR_W-1:0] addr_sig,
  output logic [DATA_W-1:0] wr_data,
  input  logic              done_sig,
  input  logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              test_done,
  output logic              pass,
  output logic [ERR_W-1:0]  err_cnt,
  output logic              timeout_err
);

  // Counter widths always hold their terminal value, even for tiny parameters
  localparam int GAP_W = $clog2(WR_GAP_CYC + 2);
  localparam int TO_W  = $clog2(TIMEOUT_CYC + 2);

  // Gap counter counts down to zero, so it is loaded with one less than the gap
  localparam logic [GAP_W-1:0]  GAP_LOAD = GAP_W'((WR_GAP_CYC > 0) ? WR_GAP_CYC - 1 : 0);
  localparam logic [TO_W-1:0]   TO_LAST  = TO_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_BYTES - 1);

  typedef enum logic [2:0] {
    IDLE, WR_REQ, WR_GAP, RD_REQ, RD_CMP, FIN
  } state_t;

  state_t              state_q;
  logic [1:0]          mode_q;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [GAP_W-1:0]    gap_cnt_q;
  logic [TO_W-1:0]     to_cnt_q;
  logic [DATA_W-1:0]   rd_data_q;
  logic [ERR_W-1:0]    err_cnt_q, err_cnt_d;
  logic                wr_sig_q, rd_sig_q, busy_q, test_done_q, pass_q, timeout_err_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wr_data_q;

  // Word address of pattern index i; wraps naturally at 2^ADDR_W
  function automatic logic [ADDR_W-1:0] addr_of(input logic [ADDR_W-1:0] i);
    return START_ADDR + i;
  endfunction

  // Expected pattern byte for index i
  function automatic logic [DATA_W-1:0] data_of(input logic [ADDR_W-1:0] i);
    return BASE_DATA + DATA_W'(i);
  endfunction

  // Error count sticks at all-ones instead of wrapping back to zero
  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (&v) ? v : v + ERR_W'(1);
  endfunction

  // Next index and the error count including this cycle's read-back compare
  always_comb begin
    idx_d     = idx_q + ADDR_W'(1);
    err_cnt_d = err_cnt_q;
    if (state_q == RD_CMP && rd_data_q != data_of(idx_q))
      err_cnt_d = sat_inc(err_cnt_q);
  end

  // Sequencer FSM; every output is a register so the core sees glitch-free requests
  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      mode_q        <= 2'b00;
      idx_q         <= '0;
      gap_cnt_q     <= '0;
      to_cnt_q      <= '0;
      rd_data_q     <= '0;
      err_cnt_q     <= '0;
      wr_sig_q      <= 1'b0;
      rd_sig_q      <= 1'b0;
      addr_q        <= '0;
      wr_data_q     <= '0;
      busy_q        <= 1'b0;
      test_done_q   <= 1'b0;
      pass_q        <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      test_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            mode_q        <= mode;
            idx_q         <= '0;
            err_cnt_q     <= '0;
            pass_q        <= 1'b0;
            timeout_err_q <= 1'b0;
            busy_q        <= 1'b1;
            to_cnt_q      <= '0;
            addr_q        <= addr_of('0);
            if (mode == 2'b10) begin
              rd_sig_q <= 1'b1;
              state_q  <= RD_REQ;
            end else begin
              wr_sig_q  <= 1'b1;
              wr_data_q <= data_of('0);
              state_q   <= WR_REQ;
            end
          end
        end
        WR_REQ: begin
          // done_sig is checked first so it wins over a simultaneous timeout
          if (done_sig) begin
            wr_sig_q  <= 1'b0;
            gap_cnt_q <= GAP_LOAD;
            state_q   <= WR_GAP;
          end else if (to_cnt_q == TO_LAST) begin
            wr_sig_q      <= 1'b0;
            timeout_err_q <= 1'b1;
            pass_q        <= 1'b0;
            test_done_q   <= 1'b1;
            state_q       <= FIN;
          end else begin
            to_cnt_q <= to_cnt_q + TO_W'(1);
          end
        end
        WR_GAP: begin
          if (gap_cnt_q != '0) begin
            gap_cnt_q <= gap_cnt_q - GAP_W'(1);
          end else if (idx_q < LAST_IDX) begin
            idx_q     <= idx_d;
            addr_q    <= addr_of(idx_d);
            wr_data_q <= data_of(idx_d);
            wr_sig_q  <= 1'b1;
            to_cnt_q  <= '0;
            state_q   <= WR_REQ;
          end else begin
            idx_q <= '0;
            if (mode_q == 2'b01) begin
              test_done_q <= 1'b1;
              pass_q      <= (err_cnt_q == '0) && !timeout_err_q;
              state_q     <= FIN;
            end else begin
              addr_q   <= addr_of('0);
              rd_sig_q <= 1'b1;
              to_cnt_q <= '0;
              state_q  <= RD_REQ;
            end
          end
        end
        RD_REQ: begin
          if (done_sig) begin
            rd_data_q <= rd_data;
            rd_sig_q  <= 1'b0;
            state_q   <= RD_CMP;
          end else if (to_cnt_q == TO_LAST) begin
            rd_sig_q      <= 1'b0;
            timeout_err_q <= 1'b1;
            pass_q        <= 1'b0;
            test_done_q   <= 1'b1;
            state_q       <= FIN;
          end else begin
            to_cnt_q <= to_cnt_q + TO_W'(1);
          end
        end
        RD_CMP: begin
          err_cnt_q <= err_cnt_d;
          if (idx_q < LAST_IDX) begin
            idx_q    <= idx_d;
            addr_q   <= addr_of(idx_d);
            rd_sig_q <= 1'b1;
            to_cnt_q <= '0;
            state_q  <= RD_REQ;
          end else begin
            test_done_q <= 1'b1;
            pass_q      <= (err_cnt_d == '0) && !timeout_err_q;
            state_q     <= FIN;
          end
        end
        FIN: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign wr_sig      = wr_sig_q;
  assign rd_sig      = rd_sig_q;
  assign addr_sig    = addr_q;
  assign wr_data     = wr_data_q;
  assign busy        = busy_q;
  assign test_done   = test_done_q;
  assign pass        = pass_q;
  assign err_cnt     = err_cnt_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_iic_seq_ctrl.sv
// tb_iic_seq_ctrl: scoreboard bench for iic_seq_ctrl. Two instances differ only
// in START_ADDR (0 and FE); a shared EEPROM/IIC core model serves whichever
// instance is selected. Expected transactions are queued per test; a monitor
// pops and compares each request, and each test_done, as the DUT presents it.
module tb_iic_seq_ctrl;

  logic       clk_50M = 1'b0;
  logic       rst_n   = 1'b0;
  logic       start_a = 1'b0;
  logic       start_b = 1'b0;
  logic [1:0] mode    = 2'b00;
  logic       done    = 1'b0;
  logic [7:0] rd_data = 8'h00;
  logic       sel     = 1'b0;

  logic       a_wr, a_rd, a_busy, a_td, a_pass, a_to;
  logic [7:0] a_addr, a_wdata, a_err;
  logic       b_wr, b_rd, b_busy, b_td, b_pass, b_to;
  logic [7:0] b_addr, b_wdata, b_err;
  logic       done_a, done_b;

  logic       m_wr, m_rd, m_busy, m_td, m_pass, m_to;
  logic [7:0] m_addr, m_wdata, m_err;

  assign done_a  = sel ? 1'b0 : done;
  assign done_b  = sel ? done : 1'b0;
  assign m_wr    = sel ? b_wr    : a_wr;
  assign m_rd    = sel ? b_rd    : a_rd;
  assign m_busy  = sel ? b_busy  : a_busy;
  assign m_td    = sel ? b_td    : a_td;
  assign m_pass  = sel ? b_pass  : a_pass;
  assign m_to    = sel ? b_to    : a_to;
  assign m_addr  = sel ? b_addr  : a_addr;
  assign m_wdata = sel ? b_wdata : a_wdata;
  assign m_err   = sel ? b_err   : a_err;

  iic_seq_ctrl #(
    .ADDR_W(8), .DATA_W(8), .NUM_BYTES(4), .START_ADDR(8'h00), .BASE_DATA(8'hA5),
    .WR_GAP_CYC(3), .TIMEOUT_CYC(10), .ERR_W(8)
  ) u_dut_a (
    .clk_50M(clk_50M), .rst_n(rst_n), .start(start_a), .mode(mode),
    .wr_sig(a_wr), .rd_sig(a_rd), .addr_sig(a_addr), .wr_data(a_wdata),
    .done_sig(done_a), .rd_data(rd_data), .busy(a_busy), .test_done(a_td),
    .pass(a_pass), .err_cnt(a_err), .timeout_err(a_to)
  );

  iic_seq_ctrl #(
    .ADDR_W(8), .DATA_W(8), .NUM_BYTES(4), .START_ADDR(8'hFE), .BASE_DATA(8'hA5),
    .WR_GAP_CYC(3), .TIMEOUT_CYC(10), .ERR_W(8)
  ) u_dut_b (
    .clk_50M(clk_50M), .rst_n(rst_n), .start(start_b), .mode(mode),
    .wr_sig(b_wr), .rd_sig(b_rd), .addr_sig(b_addr), .wr_data(b_wdata),
    .done_sig(done_b), .rd_data(rd_data), .busy(b_busy), .test_done(b_td),
    .pass(b_pass), .err_cnt(b_err), .timeout_err(b_to)
  );

  always #10 clk_50M = ~clk_50M;

  typedef struct {
    int         kind;   // 1 = write request, 2 = read request, 3 = test end
    logic [7:0] f1;     // address, or {pass, timeout_err, busy, 5'b0}
    logic [7:0] f2;     // write data, 0 for reads, err_cnt for test end
    int         idle;   // idle cycles before the event, -1 = don't care
  } ev_t;

  ev_t exp_q[$];

  int total = 0;
  int bad   = 0;
  int td_count  = 0;
  int td_wide   = 0;
  int mutex_bad = 0;
  int last_len  = 0;

  logic       no_answer   = 1'b0;
  logic       corrupt_en  = 1'b0;
  logic [7:0] corrupt_adr = 8'h00;
  logic [7:0] mem [0:255];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic push_w(input logic [7:0] a, input logic [7:0] d, input int idle);
    ev_t e;
    e.kind = 1; e.f1 = a; e.f2 = d; e.idle = idle;
    exp_q.push_back(e);
  endtask

  task automatic push_r(input logic [7:0] a, input int idle);
    ev_t e;
    e.kind = 2; e.f1 = a; e.f2 = 8'h00; e.idle = idle;
    exp_q.push_back(e);
  endtask

  task automatic push_d(input logic p, input logic to, input logic [7:0] err, input int idle);
    ev_t e;
    e.kind = 3; e.f1 = {p, to, 1'b1, 5'b00000}; e.f2 = err; e.idle = idle;
    exp_q.push_back(e);
  endtask

  task automatic take(input int kind, input logic [7:0] f1, input logic [7:0] f2,
                      input int idle, input string nm);
    ev_t e;
    if (exp_q.size() == 0) begin
      chk({nm, "_unexpected"}, 64'(kind), 64'd0);
    end else begin
      e = exp_q.pop_front();
      chk(nm, 64'({8'(kind), f1, f2, 16'(idle)}),
              64'({8'(e.kind), e.f1, e.f2, (e.idle < 0) ? 16'(idle) : 16'(e.idle)}));
    end
  endtask

  // EEPROM + IIC core model: answers each request with a done pulse two cycles in
  initial begin
    bit answered;
    int lat;
    answered = 1'b0;
    lat = 0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    forever begin
      @(negedge clk_50M);
      done = 1'b0;
      if (m_wr || m_rd) begin
        if (!answered && !no_answer) begin
          if (lat >= 1) begin
            done = 1'b1;
            answered = 1'b1;
            if (m_wr) mem[m_addr] = m_wdata;
            else rd_data = mem[m_addr] ^ ((corrupt_en && m_addr == corrupt_adr) ? 8'h01 : 8'h00);
          end else begin
            lat++;
          end
        end
      end else begin
        answered = 1'b0;
        lat = 0;
      end
    end
  end

  // Monitor: pops the scoreboard on every new request and every test_done
  initial begin
    logic prev_wr, prev_rd, prev_td;
    int   idle, req_len;
    prev_wr = 1'b0; prev_rd = 1'b0; prev_td = 1'b0;
    idle = 0; req_len = 0;
    forever begin
      @(negedge clk_50M);
      if ((a_wr && a_rd) || (b_wr && b_rd)) mutex_bad++;
      if (m_wr && !prev_wr) take(1, m_addr, m_wdata, idle, "wr_txn");
      if (m_rd && !prev_rd) take(2, m_addr, 8'h00, idle, "rd_txn");
      if (m_td && !prev_td) begin
        take(3, {m_pass, m_to, m_busy, 5'b00000}, m_err, idle, "test_end");
        td_count++;
      end
      if (m_td && prev_td) td_wide++;
      if (m_wr || m_rd) begin
        if (!(prev_wr || prev_rd)) req_len = 1;
        else req_len++;
        last_len = req_len;
        idle = 0;
      end else begin
        idle++;
      end
      prev_wr = m_wr; prev_rd = m_rd; prev_td = m_td;
    end
  end

  task automatic push_full(input logic [7:0] a0, input logic p, input logic [7:0] err);
    push_w(a0,         8'hA5, -1);
    push_w(a0 + 8'd1,  8'hA6, 3);
    push_w(a0 + 8'd2,  8'hA7, 3);
    push_w(a0 + 8'd3,  8'hA8, 3);
    push_r(a0,         3);
    push_r(a0 + 8'd1,  1);
    push_r(a0 + 8'd2,  1);
    push_r(a0 + 8'd3,  1);
    push_d(p, 1'b0, err, 1);
  endtask

  task automatic run_test(input logic s, input logic [1:0] md, input logic exp_pass);
    int td0;
    int n;
    sel = s;
    mode = md;
    td0 = td_count;
    @(negedge clk_50M);
    if (s) start_b = 1'b1;
    else start_a = 1'b1;
    // start held high while busy must not restart the sequence
    repeat (4) @(negedge clk_50M);
    start_a = 1'b0;
    start_b = 1'b0;
    n = 0;
    while (td_count == td0 && n < 400) begin
      @(negedge clk_50M);
      n++;
    end
    repeat (3) @(negedge clk_50M);
    chk("done_pulses", 64'(td_count - td0), 64'd1);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    chk("busy_after", 64'(m_busy), 64'd0);
    chk("pass_held", 64'(m_pass), 64'(exp_pass));
    exp_q.delete();
  endtask

  initial begin
    int td0;
    int n;
    #30;
    chk("reset_ctrl", 64'({a_wr, a_rd, a_busy, a_td, a_pass, a_to}), 64'd0);
    chk("reset_data", 64'({a_addr, a_wdata, a_err}), 64'd0);
    @(negedge clk_50M);
    rst_n = 1'b1;
    repeat (2) @(negedge clk_50M);

    // mode 00, clean echo
    push_full(8'h00, 1'b1, 8'd0);
    run_test(1'b0, 2'b00, 1'b1);

    // mode 00, read of address 2 corrupted
    corrupt_en = 1'b1; corrupt_adr = 8'h02;
    push_full(8'h00, 1'b0, 8'd1);
    run_test(1'b0, 2'b00, 1'b0);
    corrupt_en = 1'b0;

    // mode 11 behaves as 00
    push_full(8'h00, 1'b1, 8'd0);
    run_test(1'b0, 2'b11, 1'b1);

    // mode 01, write only: test ends right after the last gap
    push_w(8'h00, 8'hA5, -1);
    push_w(8'h01, 8'hA6, 3);
    push_w(8'h02, 8'hA7, 3);
    push_w(8'h03, 8'hA8, 3);
    push_d(1'b1, 1'b0, 8'd0, 3);
    run_test(1'b0, 2'b01, 1'b1);

    // mode 10, verify only against the pattern already stored
    push_r(8'h00, -1);
    push_r(8'h01, 1);
    push_r(8'h02, 1);
    push_r(8'h03, 1);
    push_d(1'b1, 1'b0, 8'd0, 1);
    run_test(1'b0, 2'b10, 1'b1);

    // address wrap FE, FF, 00, 01
    push_full(8'hFE, 1'b1, 8'd0);
    run_test(1'b1, 2'b00, 1'b1);

    // core never answers: write dropped after 10 cycles, timeout flagged
    no_answer = 1'b1;
    push_w(8'h00, 8'hA5, -1);
    push_d(1'b0, 1'b1, 8'd0, 0);
    run_test(1'b0, 2'b00, 1'b0);
    chk("timeout_req_len", 64'(last_len), 64'd10);
    chk("timeout_flag_held", 64'(a_to), 64'd1);
    no_answer = 1'b0;

    // reset pulsed while a read is outstanding
    sel = 1'b0;
    mode = 2'b00;
    push_w(8'h00, 8'hA5, -1);
    push_w(8'h01, 8'hA6, 3);
    push_w(8'h02, 8'hA7, 3);
    push_w(8'h03, 8'hA8, 3);
    push_r(8'h00, 3);
    @(negedge clk_50M);
    start_a = 1'b1;
    repeat (4) @(negedge clk_50M);
    start_a = 1'b0;
    n = 0;
    while (!a_rd && n < 200) begin
      @(negedge clk_50M);
      n++;
    end
    chk("rd_reached", 64'(a_rd), 64'd1);
    td0 = td_count;
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_ctrl", 64'({a_wr, a_rd, a_busy, a_td, a_pass, a_to}), 64'd0);
    chk("midrst_data", 64'({a_addr, a_wdata, a_err}), 64'd0);
    repeat (3) @(negedge clk_50M);
    rst_n = 1'b1;
    repeat (10) @(negedge clk_50M);
    chk("no_done_after_rst", 64'(td_count - td0), 64'd0);
    chk("idle_after_rst", 64'({a_wr, a_rd, a_busy}), 64'd0);
    chk("queue_at_rst", 64'(exp_q.size()), 64'd0);
    exp_q.delete();

    // full test after reset
    push_full(8'h00, 1'b1, 8'd0);
    run_test(1'b0, 2'b00, 1'b1);

    chk("wr_rd_exclusive", 64'(mutex_bad), 64'd0);
    chk("done_one_cycle", 64'(td_wide), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
